// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus, with locked sequences
// and a forced lock release after the owner stays silent for LOCK_TMO idle cycles.
module bus_rr_arbiter #(
    parameter int unsigned LOCK_TMO = 64,
    parameter int unsigned TMO_W    = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic        m0_lock_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic        m1_lock_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_rd_o,
    output logic        s_wr_o,
    input  logic [31:0] s_data_i,
    output logic [1:0]  owner_o,
    output logic        lock_tmo_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0]       r_state;
    logic             r_sel;
    logic             r_last;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_m0_rdata;
    logic [31:0]      r_m1_rdata;
    logic [1:0]       r_owner;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_locked;
    logic w_own_req;
    logic w_tmo_hit;
    logic w_grant;
    logic w_win;
    logic w_win_lock;

    assign w_locked   = (r_owner != 2'b00);
    assign w_own_req  = (r_owner[0] & m0_req_i) | (r_owner[1] & m1_req_i);
    // Release fires only when the owner is silent in the cycle the count is full.
    assign w_tmo_hit  = (r_state == ST_IDLE) & w_locked & ~w_own_req &
                        (r_tmo_cnt == TMO_W'(LOCK_TMO));
    assign w_win_lock = r_sel ? m1_lock_i : m0_lock_i;

    always_comb begin
        w_grant = 1'b0;
        w_win   = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_locked) begin
                w_grant = w_own_req;
                w_win   = r_owner[1];
            end else if (m0_req_i && m1_req_i) begin
                w_grant = 1'b1;
                w_win   = ~r_last;
            end else if (m0_req_i) begin
                w_grant = 1'b1;
                w_win   = 1'b0;
            end else if (m1_req_i) begin
                w_grant = 1'b1;
                w_win   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_owner    <= 2'b00;
            r_tmo_cnt  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_tmo_hit) begin
                        r_owner   <= 2'b00;
                        r_tmo_cnt <= '0;
                    end else if (w_locked && !w_own_req) begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end else begin
                        r_tmo_cnt <= '0;
                    end
                    if (w_grant) begin
                        r_sel   <= w_win;
                        r_we    <= w_win ? m1_we_i : m0_we_i;
                        r_addr  <= w_win ? m1_addr_i : m0_addr_i;
                        r_wdata <= w_win ? m1_data_i : m0_data_i;
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (!r_we) begin
                        if (r_sel) begin
                            r_m1_rdata <= s_data_i;
                        end else begin
                            r_m0_rdata <= s_data_i;
                        end
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_last  <= r_sel;
                    r_owner <= w_win_lock ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_rd_o     = (r_state == ST_STROBE) & ~r_we;
    assign s_wr_o     = (r_state == ST_STROBE) & r_we;
    assign m0_ack_o   = (r_state == ST_ACK) & ~r_sel;
    assign m1_ack_o   = (r_state == ST_ACK) & r_sel;
    assign s_addr_o   = r_addr;
    assign s_data_o   = r_wdata;
    assign m0_data_o  = r_m0_rdata;
    assign m1_data_o  = r_m1_rdata;
    assign owner_o    = r_owner;
    assign lock_tmo_o = w_tmo_hit;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed cases with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_bus_rr_arbiter;

    localparam int LOCK_TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  t_req;
    logic [1:0]  t_we;
    logic [1:0]  t_lock;
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];

    logic [31:0] m0_data, m1_data, s_addr, s_wdata, s_rdata;
    logic        m0_ack, m1_ack, s_rd, s_wr, lock_tmo;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (a == 32'h2100_0004) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign s_rdata = slave_rd(s_addr);

    bus_rr_arbiter #(.LOCK_TMO(64), .TMO_W(7)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_req_i   (t_req[0]),
        .m0_we_i    (t_we[0]),
        .m0_lock_i  (t_lock[0]),
        .m0_addr_i  (t_addr[0]),
        .m0_data_i  (t_wdata[0]),
        .m0_data_o  (m0_data),
        .m0_ack_o   (m0_ack),
        .m1_req_i   (t_req[1]),
        .m1_we_i    (t_we[1]),
        .m1_lock_i  (t_lock[1]),
        .m1_addr_i  (t_addr[1]),
        .m1_data_i  (t_wdata[1]),
        .m1_data_o  (m1_data),
        .m1_ack_o   (m1_ack),
        .s_addr_o   (s_addr),
        .s_data_o   (s_wdata),
        .s_rd_o     (s_rd),
        .s_wr_o     (s_wr),
        .s_data_i   (s_rdata),
        .owner_o    (owner),
        .lock_tmo_o (lock_tmo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: stage 0 = bus free, 1 = strobe, 2 = acknowledge.
    int          md_stage, md_win, md_last, md_owner, md_quiet;
    logic        md_we;
    logic [31:0] md_addr, md_wdata;
    logic [31:0] md_rdata [2];
    logic        md_valid = 1'b0;
    logic [1:0]  e_ack = 2'b00;
    logic        e_rd, e_wr, e_tmo;
    logic [1:0]  e_own;

    task automatic md_grant(input int m);
        md_win   = m;
        md_we    = t_we[m];
        md_addr  = t_addr[m];
        md_wdata = t_wdata[m];
        md_stage = 1;
    endtask

    always @(negedge clk) begin
        if (md_valid) begin
            e_rd     = (md_stage == 1) && !md_we;
            e_wr     = (md_stage == 1) && md_we;
            e_ack[0] = (md_stage == 2) && (md_win == 0);
            e_ack[1] = (md_stage == 2) && (md_win == 1);
            e_own    = (md_owner < 0) ? 2'b00 : ((md_owner == 0) ? 2'b01 : 2'b10);
            e_tmo    = (md_stage == 0) && (md_owner >= 0) && (md_quiet == LOCK_TMO) &&
                       !((md_owner == 0) ? t_req[0] : t_req[1]);
            check("cmp_ctrl", 32'({m0_ack, m1_ack, s_rd, s_wr, owner, lock_tmo}),
                  32'({e_ack[0], e_ack[1], e_rd, e_wr, e_own, e_tmo}));
            check("cmp_s_addr", s_addr, md_addr);
            check("cmp_s_data", s_wdata, md_wdata);
            check("cmp_m0_data", m0_data, md_rdata[0]);
            check("cmp_m1_data", m1_data, md_rdata[1]);
        end
        if (rst) begin
            md_stage = 0; md_win = 0; md_last = 1; md_owner = -1; md_quiet = 0;
            md_we = 1'b0; md_addr = '0; md_wdata = '0;
            md_rdata[0] = '0; md_rdata[1] = '0;
            md_valid = 1'b1;
        end else if (md_valid) begin
            case (md_stage)
                0: begin
                    if (md_owner >= 0) begin
                        if (t_req[md_owner]) begin
                            md_quiet = 0;
                            md_grant(md_owner);
                        end else if (md_quiet == LOCK_TMO) begin
                            md_owner = -1;
                            md_quiet = 0;
                        end else begin
                            md_quiet++;
                        end
                    end else if (t_req[0] && t_req[1]) begin
                        md_grant(1 - md_last);
                    end else if (t_req[0]) begin
                        md_grant(0);
                    end else if (t_req[1]) begin
                        md_grant(1);
                    end
                end
                1: begin
                    if (!md_we) md_rdata[md_win] = slave_rd(md_addr);
                    md_stage = 2;
                end
                default: begin
                    md_last  = md_win;
                    md_owner = t_lock[md_win] ? md_win : -1;
                    md_quiet = 0;
                    md_stage = 0;
                end
            endcase
        end
    end

    task automatic single_access(input int m, input logic we, input logic [31:0] a,
                                 input logic [31:0] d);
        t_req[m] = 1'b1; t_we[m] = we; t_lock[m] = 1'b0; t_addr[m] = a; t_wdata[m] = d;
        tick(); tick(); tick();
        t_req[m] = 1'b0;
    endtask

    int order [$];
    int quiet [2];
    int k, a0, tp, a1, ntmo;
    logic dual, pend_own, done, early, m0_seen, m1_seen;
    logic [1:0] exp_own;
    logic [1:0] ack_prev;
    logic [2:0] lk;

    initial begin
        rst = 1'b1; t_req = '0; t_we = '0; t_lock = '0;
        for (int m = 0; m < 2; m++) begin t_addr[m] = '0; t_wdata[m] = '0; end
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'({m0_ack, m1_ack, s_rd, s_wr, owner, lock_tmo}), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_m0_data", m0_data, 32'd0);

        // Single write from m0.
        tick();
        t_req[0] = 1'b1; t_we[0] = 1'b1; t_lock[0] = 1'b0;
        t_addr[0] = 32'h2000_0000; t_wdata[0] = 32'h55;
        @(negedge clk);
        check("wr_c1_idle", 32'({s_wr, s_rd, m0_ack}), 32'd0);
        tick(); @(negedge clk);
        check("wr_c2_strobe", 32'({s_wr, s_rd, m0_ack}), 32'b100);
        check("wr_addr", s_addr, 32'h2000_0000);
        check("wr_data", s_wdata, 32'h55);
        tick(); @(negedge clk);
        check("wr_c3_ack", 32'({s_wr, s_rd, m0_ack, m1_ack}), 32'b0010);
        tick();
        t_req[0] = 1'b0;

        // Read from m1.
        t_req[1] = 1'b1; t_we[1] = 1'b0; t_lock[1] = 1'b0; t_addr[1] = 32'h2100_0004;
        tick(); @(negedge clk);
        check("rd_strobe", 32'({s_rd, s_wr}), 32'b10);
        tick(); @(negedge clk);
        check("rd_ack", 32'({m0_ack, m1_ack}), 32'b01);
        check("rd_data", m1_data, 32'hDEAD_BEEF);
        tick();
        t_req[1] = 1'b0;

        // Contention: both request continuously for six accesses.
        t_req = 2'b11; t_we = 2'b11; t_lock = 2'b00;
        t_addr[0] = 32'h2000_0100; t_addr[1] = 32'h2100_0100;
        dual = 1'b0;
        order.delete();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if ((s_rd && s_wr) || (m0_ack && m1_ack)) dual = 1'b1;
            if (m0_ack) order.push_back(0);
            if (m1_ack) order.push_back(1);
            tick();
        end
        t_req = 2'b00;
        check("cont_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size() && i < 6; i++) check("cont_order", 32'(order[i]), 32'(i % 2));
        check("cont_dual", 32'(dual), 32'd0);

        // Locked sequence: m0 lock=1,1,0 while m1 requests throughout.
        tick();
        lk = 3'b011;
        k = 0; pend_own = 1'b0; exp_own = 2'b00;
        t_req = 2'b11; t_we = 2'b01; t_lock[0] = lk[0]; t_lock[1] = 1'b0;
        t_addr[0] = 32'h2000_0010; t_wdata[0] = 32'h0; t_addr[1] = 32'h2100_0008;
        order.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            m0_seen = m0_ack; m1_seen = m1_ack;
            if (pend_own) begin check("lock_owner", 32'(owner), 32'(exp_own)); pend_own = 1'b0; end
            if (m0_ack) begin
                order.push_back(0);
                pend_own = 1'b1;
                exp_own = (k < 2) ? 2'b01 : 2'b00;
                k++;
            end
            if (m1_ack) order.push_back(1);
            tick();
            if (m0_seen) begin
                if (k < 3) begin t_lock[0] = lk[k]; t_wdata[0] = 32'(k); end
                else t_req[0] = 1'b0;
            end
            if (m1_seen) t_req[1] = 1'b0;
        end
        check("lock_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            check("lock_order", 32'(order[i]), (i < 3) ? 32'd0 : 32'd1);

        // Lock timeout: m0 locks then goes silent; m1 waits.
        tick();
        t_req = 2'b01; t_we = 2'b11; t_lock = 2'b01; t_addr[0] = 32'h2000_0020;
        t_addr[1] = 32'h2100_0010;
        a0 = -1; tp = -1; a1 = -1; ntmo = 0; done = 1'b0;
        for (int i = 1; i <= 120 && !done; i++) begin
            @(negedge clk);
            m0_seen = m0_ack; m1_seen = m1_ack;
            if (m0_ack && a0 < 0) a0 = i;
            if (a0 >= 0 && i == a0 + 1) check("tmo_owner_locked", 32'(owner), 32'b01);
            if (tp >= 0 && i == tp + 1) check("tmo_owner_free", 32'(owner), 32'b00);
            if (lock_tmo) begin if (tp < 0) tp = i; ntmo++; end
            if (m1_ack && a1 < 0) a1 = i;
            tick();
            if (m0_seen) begin t_req[0] = 1'b0; t_lock[0] = 1'b0; t_req[1] = 1'b1; end
            if (m1_seen) begin t_req[1] = 1'b0; done = 1'b1; end
        end
        check("tmo_pulse_delay", 32'(tp - a0), 32'd65);
        check("tmo_m1_ack_delay", 32'(a1 - tp), 32'd3);
        check("tmo_pulse_count", 32'(ntmo), 32'd1);

        // Reset during a strobe; leave pointer at m0 first so m1 would win pre-reset.
        tick();
        single_access(0, 1'b1, 32'h2000_0040, 32'h77);
        tick();
        t_req = 2'b11; t_we = 2'b11; t_lock = 2'b00;
        t_addr[0] = 32'h2000_0030; t_addr[1] = 32'h2100_0030;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_pre_strobe", 32'({s_wr, s_rd}), 32'b10);
        check("rst_pre_addr", s_addr, 32'h2100_0030);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", 32'({m0_ack, m1_ack, s_rd, s_wr, owner, lock_tmo}), 32'd0);
        check("rst_mid_addr", s_addr, 32'd0);
        check("rst_mid_m1_data", m1_data, 32'd0);
        tick(); @(negedge clk);
        early = m0_ack | m1_ack;
        check("rst_no_ack", 32'(early), 32'd0);
        tick(); @(negedge clk);
        check("rst_first_tie", 32'({m0_ack, m1_ack}), 32'b10);
        tick();
        t_req = 2'b00;
        repeat (3) tick();

        // Randomized traffic; the model compares every cycle.
        quiet[0] = 0; quiet[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            ack_prev = e_ack;
            for (int m = 0; m < 2; m++) begin
                if (quiet[m] > 0) begin
                    quiet[m]--;
                    t_req[m] = 1'b0;
                end else if (!(t_req[m] && !ack_prev[m])) begin
                    if ($urandom_range(0, 199) == 0) begin
                        quiet[m] = $urandom_range(60, 90);
                        t_req[m] = 1'b0;
                    end else begin
                        t_req[m]   = ($urandom_range(0, 2) != 0);
                        t_we[m]    = 1'($urandom_range(0, 1));
                        t_lock[m]  = ($urandom_range(0, 3) == 0);
                        t_addr[m]  = {(m == 1) ? 8'h21 : 8'h20, 16'h0,
                                      6'($urandom_range(0, 63)), 2'b00};
                        t_wdata[m] = $urandom;
                    end
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        t_req = 2'b00;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
